// File: rtl/cpu_mem_pkg.sv
// Shared data-memory types: read-return owner encoding
// and the byte-address to word-index helper.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_EXT  = 2'b10
  } own_e;

  localparam int WORD_SHIFT = 3;

  // Word index of a 64-bit byte address; caller keeps the low bits it needs.
  function automatic logic [63:0] word_index(input logic [63:0] addr);
    return addr >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts cycles the external port has waited behind the CPU and
// raises force_ext once the wait limit is reached.
module dmem_starve_ctr #(
  parameter int EXT_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic ext_wait,
  input  logic ext_grant,
  output logic force_ext
);

  localparam logic [3:0] MAXW = 4'(EXT_MAX_WAIT);

  logic [3:0] r_cnt;

  // Clear when ext is idle or served, else count up to the limit.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_cnt <= 4'd0;
    end else if (!ext_wait || ext_grant) begin
      r_cnt <= 4'd0;
    end else if (r_cnt != MAXW) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign force_ext = (r_cnt == MAXW);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter: CPU priority, starvation escape
// for the external port, owner-tagged one-cycle read return.
module dmem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int MEM_ADDR_W   = 10,
  parameter int EXT_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_we,
  input  logic [ADDR_W-1:0]     cpu_req_addr,
  input  logic [DATA_W-1:0]     cpu_req_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  ext_req_valid,
  input  logic                  ext_req_we,
  input  logic [ADDR_W-1:0]     ext_req_addr,
  input  logic [DATA_W-1:0]     ext_req_wdata,
  output logic                  ext_req_ready,
  output logic                  ext_err,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic                  w_force_ext;
  logic                  w_ext_grant;
  logic                  w_cpu_grant;
  logic                  w_ext_oor;
  logic                  w_ext_acc;
  logic [63:0]           w_cpu_idx64;
  logic [63:0]           w_ext_idx64;
  logic [MEM_ADDR_W-1:0] w_cpu_idx;
  logic [MEM_ADDR_W-1:0] w_ext_idx;
  logic                  w_unused;

  logic [MEM_ADDR_W-1:0] r_mem_addr;
  own_e                  r_rd_owner;
  logic                  r_ext_err;

  dmem_starve_ctr #(
    .EXT_MAX_WAIT(EXT_MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .arst_n   (arst_n),
    .ext_wait (ext_req_valid),
    .ext_grant(w_ext_grant),
    .force_ext(w_force_ext)
  );

  assign w_ext_grant = arst_n & ext_req_valid &
                       (!cpu_req_valid | w_force_ext);
  assign w_cpu_grant = arst_n & cpu_req_valid & !w_ext_grant;

  // Out-of-range ext requests are consumed but never reach the SRAM.
  assign w_ext_oor = |(ext_req_addr >> (MEM_ADDR_W + 3));
  assign w_ext_acc = w_ext_grant & !w_ext_oor;

  assign w_cpu_idx64 = word_index(64'(cpu_req_addr));
  assign w_ext_idx64 = word_index(64'(ext_req_addr));
  assign w_cpu_idx   = w_cpu_idx64[MEM_ADDR_W-1:0];
  assign w_ext_idx   = w_ext_idx64[MEM_ADDR_W-1:0];
  assign w_unused    = ^{w_cpu_idx64, w_ext_idx64};

  // Steer the granted request onto the SRAM port; address holds when idle.
  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = r_mem_addr;
    mem_wdata = cpu_req_wdata;
    unique case (1'b1)
      w_ext_acc: begin
        mem_wen   = ext_req_we;
        mem_ren   = !ext_req_we;
        mem_addr  = w_ext_idx;
        mem_wdata = ext_req_wdata;
      end
      w_cpu_grant: begin
        mem_wen   = cpu_req_we;
        mem_ren   = !cpu_req_we;
        mem_addr  = w_cpu_idx;
        mem_wdata = cpu_req_wdata;
      end
      default: ;
    endcase
  end

  // Remember the last driven address so it holds across idle cycles.
  always_ff @(posedge clk) begin
    if (!arst_n) r_mem_addr <= '0;
    else         r_mem_addr <= mem_addr;
  end

  // Tag the read issued this cycle so its data returns to the right port.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_rd_owner <= OWN_NONE;
    end else if (w_ext_acc && !ext_req_we) begin
      r_rd_owner <= OWN_EXT;
    end else if (w_cpu_grant && !cpu_req_we) begin
      r_rd_owner <= OWN_CPU;
    end else begin
      r_rd_owner <= OWN_NONE;
    end
  end

  // One-cycle error pulse for a dropped out-of-range ext request.
  always_ff @(posedge clk) begin
    if (!arst_n) r_ext_err <= 1'b0;
    else         r_ext_err <= w_ext_grant & w_ext_oor;
  end

  assign cpu_stall     = cpu_req_valid & !w_cpu_grant;
  assign ext_req_ready = w_ext_grant;
  assign ext_err       = r_ext_err;
  assign cpu_rvalid    = (r_rd_owner == OWN_CPU);
  assign ext_rvalid    = (r_rd_owner == OWN_EXT);
  assign cpu_rdata     = mem_rdata;
  assign ext_rdata     = mem_rdata;

endmodule
